// File: rtl/vga_timing_if.sv
// vga_timing_if: run enable plus the raster timing outputs of vga_timing_ctrl.
//   master - the timing generator: takes en, drives every timing signal
//   slave  - a display pipeline: drives en, consumes the timing signals
//   en          run enable; 0 freezes all timing state
//   pix_tick    one-clk pixel enable, every second clk while en=1
//   hcount      current pixel column, 0..H_TOTAL-1
//   vcount      current line, 0..V_TOTAL-1
//   hsync       horizontal sync, active low
//   vsync       vertical sync, active low
//   video_on    1 inside the visible region
//   line_end    pulse on the last pixel tick of each line
//   frame_start pulse on the first pixel tick of each frame
`timescale 1ns/1ps
interface vga_timing_if;
    logic       en;
    logic       pix_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_end;
    logic       frame_start;

    modport master (
        input  en,
        output pix_tick, hcount, vcount, hsync, vsync, video_on, line_end, frame_start
    );

    modport slave (
        output en,
        input  pix_tick, hcount, vcount, hsync, vsync, video_on, line_end, frame_start
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator. A divide-by-two phase bit turns
// the board clock into a pixel enable; column/line counters advance on that
// enable and the sync/visible flags are zero-latency decodes of the counters.
//   clk  board clock, all state changes on its rising edge
//   clr  asynchronous active-high reset (phase, hcount, vcount to 0)
//   vif  vga_timing_if.master: en in, pix_tick/hcount/vcount/hsync/vsync/
//        video_on/line_end/frame_start out
// H_TOTAL and V_TOTAL must fit the 10-bit counters (<= 1024).
`timescale 1ns/1ps
module vga_timing_ctrl #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic         clk,
    input  logic         clr,
    vga_timing_if.master vif
);
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic             phase_q;
    logic [CNT_W-1:0] hcount_q;
    logic [CNT_W-1:0] vcount_q;
    logic             tick_c;
    logic             h_last_c;
    logic             v_last_c;

    // Gating with en keeps every pulse low while frozen, even with phase_q=1.
    assign tick_c   = phase_q & vif.en;
    assign h_last_c = (hcount_q == H_LAST);
    assign v_last_c = (vcount_q == V_LAST);

    // Phase and raster counters; inside the en branch phase_q equals tick_c.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            phase_q  <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (vif.en) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
                if (h_last_c) begin
                    hcount_q <= '0;
                    vcount_q <= v_last_c ? '0 : vcount_q + CNT_W'(1);
                end else begin
                    hcount_q <= hcount_q + CNT_W'(1);
                end
            end
        end
    end

    // Zero-latency decodes of the counter registers.
    assign vif.pix_tick    = tick_c;
    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.hsync       = ~((hcount_q >= H_SYNC_BEG) && (hcount_q < H_SYNC_END));
    assign vif.vsync       = ~((vcount_q >= V_SYNC_BEG) && (vcount_q < V_SYNC_END));
    assign vif.video_on    = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
    assign vif.line_end    = tick_c & h_last_c;
    assign vif.frame_start = tick_c & (hcount_q == '0) & (vcount_q == '0);
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: two instances (default 640x480 timing and a small raster)
// checked every cycle against an arithmetic model driven by the count of
// enabled clock edges since reset, plus literal timing expectations.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;
    logic clk = 1'b0;
    logic clr;
    logic en;

    int vectors     = 0;
    int miscompares = 0;

    // Enabled clk edges since the last reset: the whole model state.
    int n = 0;

    vga_timing_if d_if ();
    vga_timing_if s_if ();
    assign d_if.en = en;
    assign s_if.en = en;

    vga_timing_ctrl u_dflt (
        .clk (clk),
        .clr (clr),
        .vif (d_if)
    );

    vga_timing_ctrl #(
        .H_VIS(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk (clk),
        .clr (clr),
        .vif (s_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge clr) begin
        if (clr) n <= 0;
        else if (en) n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs from raster arithmetic: pixel index = n/2.
    task automatic compare_inst(input string tag,
                                input int hv, input int hfp, input int hs, input int hbp,
                                input int vv, input int vfp, input int vs, input int vbp,
                                input logic [9:0] hc, input logic [9:0] vc,
                                input logic pt, input logic hsy, input logic vsy,
                                input logic von, input logic le, input logic fs);
        int   ht, vt, p, ehc, evc;
        logic ept;
        ht  = hv + hfp + hs + hbp;
        vt  = vv + vfp + vs + vbp;
        p   = n / 2;
        ehc = p % ht;
        evc = (p / ht) % vt;
        ept = en && ((n % 2) == 1);
        check({tag, ".hcount"},      32'(hc),  32'(ehc));
        check({tag, ".vcount"},      32'(vc),  32'(evc));
        check({tag, ".pix_tick"},    32'(pt),  32'(ept));
        check({tag, ".hsync"},       32'(hsy), 32'(!((ehc >= hv + hfp) && (ehc < hv + hfp + hs))));
        check({tag, ".vsync"},       32'(vsy), 32'(!((evc >= vv + vfp) && (evc < vv + vfp + vs))));
        check({tag, ".video_on"},    32'(von), 32'((ehc < hv) && (evc < vv)));
        check({tag, ".line_end"},    32'(le),  32'(ept && (ehc == ht - 1)));
        check({tag, ".frame_start"}, 32'(fs),  32'(ept && (ehc == 0) && (evc == 0)));
    endtask

    always @(negedge clk) begin
        compare_inst("d", 640, 16, 96, 48, 480, 10, 2, 33,
                     d_if.hcount, d_if.vcount, d_if.pix_tick, d_if.hsync, d_if.vsync,
                     d_if.video_on, d_if.line_end, d_if.frame_start);
        compare_inst("s", 20, 3, 5, 4, 10, 2, 2, 3,
                     s_if.hcount, s_if.vcount, s_if.pix_tick, s_if.hsync, s_if.vsync,
                     s_if.video_on, s_if.line_end, s_if.frame_start);
    end

    // Release clr with en=1 (clr must be high on entry) and pin the restart.
    task automatic release_check();
        @(posedge clk); #2;
        clr = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        check("rel0.pix_tick", 32'(d_if.pix_tick), 32'd0);
        check("rel0.frame_start", 32'(d_if.frame_start), 32'd0);
        check("rel0.hsync", 32'(d_if.hsync), 32'd1);
        check("rel0.vsync", 32'(d_if.vsync), 32'd1);
        check("rel0.video_on", 32'(d_if.video_on), 32'd1);
        @(negedge clk);
        check("rel1.pix_tick", 32'(d_if.pix_tick), 32'd1);
        check("rel1.frame_start", 32'(d_if.frame_start), 32'd1);
        check("rel1.s_frame_start", 32'(s_if.frame_start), 32'd1);
        check("rel1.hcount", 32'(d_if.hcount), 32'd0);
        @(negedge clk);
        check("rel2.hcount", 32'(d_if.hcount), 32'd1);
        check("rel2.pix_tick", 32'(d_if.pix_tick), 32'd0);
    endtask

    // Asynchronous clr between edges: counters must clear before the next edge.
    task automatic clr_pulse(input string tag);
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        check({tag, ".async_hcount"}, 32'(d_if.hcount), 32'd0);
        check({tag, ".async_vcount"}, 32'(d_if.vcount), 32'd0);
        check({tag, ".async_hsync"}, 32'(d_if.hsync), 32'd1);
        check({tag, ".async_s_hcount"}, 32'(s_if.hcount), 32'd0);
        check({tag, ".async_s_vcount"}, 32'(s_if.vcount), 32'd0);
        check({tag, ".async_pix_tick"}, 32'(d_if.pix_tick), 32'd0);
        release_check();
    endtask

    int         first_hlow, hlow_len, le_prev, le_per, fs_prev, fs_per, vlow_len;
    bit         hdone, vdone, saw_vwrap, found;
    logic [9:0] prev_svc, held_v;

    initial begin
        clr = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.hcount", 32'(d_if.hcount), 32'd0);
        check("rst.vcount", 32'(d_if.vcount), 32'd0);
        check("rst.hsync", 32'(d_if.hsync), 32'd1);
        check("rst.vsync", 32'(d_if.vsync), 32'd1);
        check("rst.video_on", 32'(d_if.video_on), 32'd1);
        check("rst.pix_tick", 32'(d_if.pix_tick), 32'd0);

        release_check();

        // Free run: measure horizontal timing (default) and vertical timing (small).
        first_hlow = -1; hlow_len = 0; hdone = 1'b0;
        le_prev = -1; le_per = 0; fs_prev = 1; fs_per = 0;
        vlow_len = 0; vdone = 1'b0; saw_vwrap = 1'b0;
        prev_svc = s_if.vcount;
        for (int k = 3; k <= 5000; k++) begin
            @(negedge clk);
            if (!d_if.hsync) begin
                if (first_hlow < 0) first_hlow = k;
                if (!hdone) hlow_len++;
            end else if (hlow_len > 0) begin
                hdone = 1'b1;
            end
            if (d_if.line_end) begin
                if (le_prev >= 0) le_per = k - le_prev;
                le_prev = k;
            end
            if (s_if.frame_start) begin
                fs_per  = k - fs_prev;
                fs_prev = k;
            end
            if (!s_if.vsync) begin
                if (!vdone) vlow_len++;
            end else if (vlow_len > 0) begin
                vdone = 1'b1;
            end
            if (prev_svc == 10'd16 && s_if.vcount == 10'd0) saw_vwrap = 1'b1;
            prev_svc = s_if.vcount;
        end
        check("hsync_fall_edge", 32'(first_hlow), 32'd1312);
        check("hsync_low_clks", 32'(hlow_len), 32'd192);
        check("line_end_period", 32'(le_per), 32'd1600);
        check("s_frame_start_period", 32'(fs_per), 32'd1088);
        check("s_vsync_low_clks", 32'(vlow_len), 32'd128);
        check("s_vcount_wrap_seen", 32'(saw_vwrap), 32'd1);

        // Freeze at the last visible column, then resume.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (d_if.hcount == 10'd639) found = 1'b1;
        end
        check("wait_hcount_639", 32'(found), 32'd1);
        held_v = d_if.vcount;
        @(posedge clk); #2;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold.hcount", 32'(d_if.hcount), 32'd639);
            check("hold.vcount", 32'(d_if.vcount), 32'(held_v));
            check("hold.video_on", 32'(d_if.video_on), 32'd1);
            check("hold.pulses", 32'({d_if.pix_tick, d_if.line_end, d_if.frame_start}), 32'd0);
        end
        @(posedge clk); #2;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (d_if.hcount == 10'd640) found = 1'b1;
        end
        check("resume_hcount_640", 32'(found), 32'd1);
        check("resume.video_on", 32'(d_if.video_on), 32'd0);

        // Abort mid-line inside hsync on the default raster.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (d_if.hcount == 10'd700) found = 1'b1;
        end
        check("wait_hcount_700", 32'(found), 32'd1);
        check("pre_clr.hsync", 32'(d_if.hsync), 32'd0);
        clr_pulse("clr_d");

        // Abort mid-frame inside hsync on the small raster.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (s_if.hcount == 10'd25 && s_if.vcount == 10'd7) found = 1'b1;
        end
        check("wait_s_25_7", 32'(found), 32'd1);
        clr_pulse("clr_s");

        // Random enable gaps and rare asynchronous resets.
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk); #2;
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 999) == 0) begin
                #($urandom_range(1, 2));
                clr = 1'b1;
                @(posedge clk); #2;
                clr = 1'b0;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
